// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754-style floating-point divider, a / b.
// A radix-2 restoring mantissa divider produces one quotient bit per clock
// behind a valid/ready handshake. One operation is in flight at a time.
// Subnormal inputs are read as signed zeros. Results that fall below the
// minimum normal are flushed to signed zero.
// Build option FDIV_ROUND_NEAREST_EN: when defined, the quotient is rounded
// to nearest-even on guard/sticky. When undefined, it is truncated.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 exception,
  output logic                 div_by_zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;          // mantissa including hidden bit
  localparam int XW = EXP_W + 2;          // signed working exponent
  localparam int CW = $clog2(MAN_W + 2);  // iteration counter width

  localparam logic [CW-1:0]        LAST_IT = CW'(MAN_W + 1);
  localparam logic signed [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X  = XW'(0);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Operand and datapath registers
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [M:0]           rem_q, rem_d;     // partial remainder, always < 2*divisor
  logic [M-1:0]         div_q, div_d;     // divisor mantissa
  logic [M:0]           quo_q, quo_d;     // MAN_W+1 quotient bits plus guard
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 special_q, special_d;

  // Output registers
  logic [W-1:0]         result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d, dbz_q, dbz_d;

  // Field decode of the captured operands
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic [M-1:0]         ma, mb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_u;
  logic signed [XW-1:0] exp_unp;

  assign ea      = a_q[W-2:MAN_W];
  assign eb      = b_q[W-2:MAN_W];
  assign fa      = a_q[MAN_W-1:0];
  assign fb      = b_q[MAN_W-1:0];
  assign ma      = {1'b1, fa};
  assign mb      = {1'b1, fb};
  assign a_zero  = ~|ea;                   // zero or subnormal
  assign b_zero  = ~|eb;
  assign a_nan   = (&ea) & (|fa);
  assign b_nan   = (&eb) & (|fb);
  assign a_inf   = (&ea) & ~(|fa);
  assign b_inf   = (&eb) & ~(|fb);
  assign sign_u  = a_q[W-1] ^ b_q[W-1];
  assign exp_unp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;

  // One restoring step: trial subtract, quotient bit is "no borrow".
  // The difference is below the divisor, so M bits hold it exactly.
  logic         rem_ge;
  logic [M-1:0] rem_sub;

  assign rem_ge  = rem_q >= {1'b0, div_q};
  assign rem_sub = rem_q[M-1:0] - div_q;

  // Rounding of the finished quotient
  logic                 round_up, carry;
  logic [M:0]           man_sum;
  logic [MAN_W-1:0]     frac_rnd;
  logic signed [XW-1:0] exp_rnd;

`ifdef FDIV_ROUND_NEAREST_EN
  assign round_up = quo_q[0] & ((|rem_q) | quo_q[1]);
`else
  assign round_up = 1'b0;
`endif

  assign man_sum  = {1'b0, quo_q[M:1]} + {{M{1'b0}}, round_up};
  assign carry    = man_sum[M];
  assign frac_rnd = carry ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
  assign exp_rnd  = carry ? exp_q + ONE_X : exp_q;

  // Next-state and datapath control for the whole operation sequence
  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    special_d   = special_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    exc_d       = exc_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d    = sign_u;
        special_d = 1'b1;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        exc_d     = 1'b0;
        dbz_d     = 1'b0;
        // Special results skip the divider and pass through ROUND unchanged.
        state_d   = S_ROUND;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = QNAN;
          exc_d    = 1'b1;
        end else if (a_inf) begin
          result_d = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
          result_d = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          dbz_d    = 1'b1;
        end else if (a_zero || b_inf) begin
          result_d = {sign_u, {(W-1){1'b0}}};
        end else begin
          // Pre-shift the dividend so the quotient lands in [1, 2).
          special_d = 1'b0;
          exp_d     = (ma < mb) ? exp_unp - ONE_X : exp_unp;
          rem_d     = (ma < mb) ? {ma, 1'b0} : {1'b0, ma};
          div_d     = mb;
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        quo_d = {quo_q[M-1:0], rem_ge};
        rem_d = rem_ge ? {rem_sub, 1'b0} : {rem_q[M-1:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_IT) state_d = S_ROUND;
      end

      S_ROUND: begin
        if (!special_q) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          exc_d = 1'b0;
          dbz_d = 1'b0;
          if (exp_rnd >= EMAX_X) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
          end else if (exp_rnd <= ZERO_X) begin
            result_d = {sign_q, {(W-1){1'b0}}};
            unf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
          end
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and visible outputs, cleared by reset so an aborted op emits nothing
  always_ff @(posedge clk) begin
    // NOTE: registers use <= so every flop samples values from before the edge.
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      exc_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      exc_q       <= exc_d;
      dbz_q       <= dbz_d;
    end
  end

  // Datapath registers, always written before the FSM reads them
  always_ff @(posedge clk) begin
    // NOTE: no reset here; IDLE/UNPACK load every field before it is used.
    a_q       <= a_d;
    b_q       <= b_d;
    sign_q    <= sign_d;
    exp_q     <= exp_d;
    rem_q     <= rem_d;
    div_q     <= div_d;
    quo_q     <= quo_d;
    cnt_q     <= cnt_d;
    special_q <= special_d;
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign exception   = exc_q;
  assign div_by_zero = dbz_q;

endmodule
